// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2
  } icache_state_t;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_LINES  = 16;

  // Word address of offset 0 within the line selected by tag/index.
  function automatic logic [15:0] line_base(input logic [15:0] tag,
                                            input logic [15:0] index,
                                            input int          off_w,
                                            input int          idx_w);
    return (tag << (off_w + idx_w)) | (index << off_w);
  endfunction

endpackage

// File: rtl/icache_tag_store.sv
// Tag array plus per-line valid bits: combinational hit, single-line write, flush-all.
module icache_tag_store
  import icache_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_index,
  input  logic [TAG_W-1:0] i_rd_tag,
  output logic             o_hit,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_wr_valid,
  input  logic             i_flush
);

  localparam int NUM_LINES = 1 << IDX_W;

  logic [TAG_W-1:0] r_tag   [NUM_LINES];
  logic             r_valid [NUM_LINES];

  assign o_hit = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);

  // A line write wins over flush for its own entry; the caller folds flush into i_wr_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LINES; i++) begin
      if (!rst) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
      end else if (i_wr_en && (i_wr_index == IDX_W'(i))) begin
        r_valid[i] <= i_wr_valid;
        r_tag[i]   <= i_wr_tag;
      end else if (i_flush) begin
        r_valid[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped read-only instruction cache with burst line refill.
// Optional hit/miss counters enabled by defining ICACHE_STATS_EN.
module icache_fetch_unit
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_LINES  = DEF_NUM_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        fetch_en,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        mem_re,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 16 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_index;
  logic [OFF_W-1:0] w_offset;

  assign w_tag    = pc[15:OFF_W+IDX_W];
  assign w_index  = pc[OFF_W+IDX_W-1:OFF_W];
  assign w_offset = pc[OFF_W-1:0];

  icache_state_t    r_state;
  logic [TAG_W-1:0] r_miss_tag;
  logic [IDX_W-1:0] r_miss_index;
  logic [OFF_W-1:0] r_cnt;
  logic             r_abort;
  logic             r_mem_re;
  logic [15:0]      r_mem_addr;

  logic w_tag_hit;
  logic w_hit;
  logic w_in_lookup;
  logic w_hit_fetch;
  logic w_miss;
  logic w_fill_wr;
  logic w_fill_last;
  logic w_flush;

  // A flush in the lookup cycle makes the stale contents unusable immediately.
  assign w_hit       = w_tag_hit && !flush;
  assign w_in_lookup = rst && (r_state == LOOKUP);
  assign w_hit_fetch = w_in_lookup && fetch_en && w_hit;
  assign w_miss      = w_in_lookup && fetch_en && !w_hit;
  assign w_fill_wr   = rst && (r_state == FILL) && mem_rvalid;
  assign w_fill_last = w_fill_wr && (r_cnt == LAST_WORD);
  assign w_flush     = rst && flush;

  icache_tag_store #(
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_tag_store (
    .clk        (clk),
    .rst        (rst),
    .i_rd_index (w_index),
    .i_rd_tag   (w_tag),
    .o_hit      (w_tag_hit),
    .i_wr_en    (w_fill_last),
    .i_wr_index (r_miss_index),
    .i_wr_tag   (r_miss_tag),
    .i_wr_valid (!r_abort && !flush),
    .i_flush    (w_flush)
  );

  logic [15:0] r_data [NUM_LINES*LINE_WORDS];
  logic [15:0] w_rd_word;

  always_ff @(posedge clk) begin
    if (w_fill_wr) begin
      r_data[{r_miss_index, r_cnt}] <= mem_rdata;
    end
  end

  assign w_rd_word   = r_data[{w_index, w_offset}];
  assign instr       = w_hit_fetch ? w_rd_word : 16'h0000;
  assign instr_valid = w_hit_fetch;
  assign stall       = w_miss || (rst && (r_state != LOOKUP));
  assign mem_re      = r_mem_re;
  assign mem_addr    = r_mem_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= LOOKUP;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
      r_cnt        <= '0;
      r_abort      <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_addr   <= 16'h0000;
    end else begin
      r_mem_re <= 1'b0;
      case (r_state)
        LOOKUP: begin
          if (fetch_en && !w_hit) begin
            r_state      <= REQ;
            r_miss_tag   <= w_tag;
            r_miss_index <= w_index;
            r_mem_re     <= 1'b1;
            r_mem_addr   <= line_base(16'(w_tag), 16'(w_index), OFF_W, IDX_W);
          end
        end
        REQ: begin
          r_cnt   <= '0;
          r_state <= FILL;
          if (flush) r_abort <= 1'b1;
        end
        FILL: begin
          if (flush) r_abort <= 1'b1;
          // The burst always drains fully so memory and cache stay in step.
          if (mem_rvalid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_WORD) begin
              r_state <= LOOKUP;
              r_abort <= 1'b0;
            end
          end
        end
        default: r_state <= LOOKUP;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hit_cnt  <= 16'h0000;
      r_miss_cnt <= 16'h0000;
    end else begin
      if (w_hit_fetch && (r_hit_cnt != 16'hFFFF)) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (w_miss && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
